// File: rtl/angle_sensor_poller.sv
// Round-robin SPI (mode 1) poller for NUM_SENSORS angle encoders with an Avalon-MM register view.
// readdata is registered (1-cycle read latency); waitrequest is tied low, so the bus never stalls.
module angle_sensor_poller #(
  parameter int NUM_SENSORS = 9,
  parameter int CLK_DIV     = 10,
  parameter int GAP_CYCLES  = 8,
  parameter int ANGLE_BITS  = 14
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [7:0]             address,
  input  logic                   read,
  output logic [31:0]            readdata,
  input  logic                   write,
  input  logic [31:0]            writedata,
  output logic                   waitrequest,
  input  logic                   angle_miso,
  output logic                   angle_mosi,
  output logic                   angle_sck,
  output logic [NUM_SENSORS-1:0] angle_ss_n_o
);

  localparam int IDX_W = (NUM_SENSORS > 1) ? $clog2(NUM_SENSORS) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_SHIFT,
    S_DESELECT,
    S_GAP,
    S_UPDATE
  } state_t;

  state_t                 state, state_nxt;
  logic [15:0]            cnt;
  logic [4:0]             half_cnt;
  logic                   sck_q;
  logic                   mosi_q;
  logic [NUM_SENSORS-1:0] ss_n_q;
  logic [15:0]            tx_sr;
  logic [15:0]            rx_sr;
  logic [IDX_W-1:0]       idx;
  logic [IDX_W-1:0]       last_idx;
  logic [IDX_W-1:0]       next_idx;
  logic [IDX_W-1:0]       sel_nxt;
  logic                   load_idx;
  logic                   div_done;
  logic                   gap_done;
  logic                   go;
  logic                   busy;
  logic                   rx_err;

  logic                   ctrl_en;
  logic [NUM_SENSORS-1:0] mask;
  logic [15:0]            frame_cnt;
  logic [NUM_SENSORS-1:0] primed;
  logic [ANGLE_BITS-1:0]  angle  [NUM_SENSORS];
  logic                   valid  [NUM_SENSORS];
  logic                   error  [NUM_SENSORS];
  logic [15:0]            errcnt [NUM_SENSORS];
  logic [31:0]            rd_val;
  logic                   unused_wdata;

  assign waitrequest  = 1'b0;
  assign angle_sck    = sck_q;
  assign angle_mosi   = mosi_q;
  assign angle_ss_n_o = ss_n_q;
  assign unused_wdata = ^writedata;

  assign div_done = (cnt == 16'(CLK_DIV - 1));
  assign gap_done = (cnt == 16'(GAP_CYCLES - 1));
  assign go       = ctrl_en && (mask != '0);
  assign busy     = (state != S_IDLE);
  // Even parity over the whole word; bit 14 is the sensor's own error flag.
  assign rx_err   = (^rx_sr) | rx_sr[14];
  assign sel_nxt  = load_idx ? next_idx : idx;

  // Next enabled sensor strictly after last_idx, else the lowest enabled one (wrap).
  always_comb begin
    logic             hit_hi;
    logic [IDX_W-1:0] hi_idx;
    logic [IDX_W-1:0] lo_idx;
    hit_hi = 1'b0;
    hi_idx = last_idx;
    lo_idx = last_idx;
    for (int i = NUM_SENSORS - 1; i >= 0; i--) begin
      if (mask[i]) begin
        lo_idx = IDX_W'(i);
        if (i > int'(last_idx)) begin
          hi_idx = IDX_W'(i);
          hit_hi = 1'b1;
        end
      end
    end
    next_idx = hit_hi ? hi_idx : lo_idx;
  end

  always_comb begin
    state_nxt = state;
    load_idx  = 1'b0;
    case (state)
      S_IDLE: begin
        if (go) begin
          state_nxt = S_SELECT;
          load_idx  = 1'b1;
        end
      end
      S_SELECT:   if (div_done) state_nxt = S_SHIFT;
      S_SHIFT:    if (div_done && half_cnt == 5'd31) state_nxt = S_DESELECT;
      S_DESELECT: if (div_done) state_nxt = S_GAP;
      S_GAP:      if (gap_done) state_nxt = S_UPDATE;
      S_UPDATE: begin
        if (go) begin
          state_nxt = S_SELECT;
          load_idx  = 1'b1;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // SPI engine: state register, timing counters, shift registers and pin drivers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= S_IDLE;
      cnt      <= '0;
      half_cnt <= '0;
      sck_q    <= 1'b0;
      mosi_q   <= 1'b0;
      ss_n_q   <= '1;
      tx_sr    <= '0;
      rx_sr    <= '0;
      idx      <= '0;
      last_idx <= IDX_W'(NUM_SENSORS - 1);
    end else begin
      state <= state_nxt;

      if (state_nxt != state || (state == S_SHIFT && div_done)) cnt <= '0;
      else                                                       cnt <= cnt + 16'd1;

      if (load_idx) begin
        idx      <= next_idx;
        last_idx <= next_idx;
        tx_sr    <= 16'hFFFF;
      end

      if (state_nxt inside {S_SELECT, S_SHIFT, S_DESELECT})
        ss_n_q <= ~(NUM_SENSORS'(1) << sel_nxt);
      else
        ss_n_q <= '1;

      if (state == S_SELECT) half_cnt <= '0;

      // mosi launches on the rising sck edge, miso is captured on the falling one.
      if (state == S_SHIFT && div_done) begin
        sck_q    <= ~sck_q;
        half_cnt <= half_cnt + 5'd1;
        if (!sck_q) begin
          mosi_q <= tx_sr[15];
          tx_sr  <= {tx_sr[14:0], 1'b0};
        end else begin
          rx_sr <= {rx_sr[14:0], angle_miso};
        end
      end

      if (state == S_DESELECT && div_done) mosi_q <= 1'b0;
    end
  end

  // Register file, result commit and error counters.
  always_ff @(posedge clock) begin
    if (reset) begin
      ctrl_en   <= 1'b0;
      mask      <= '1;
      frame_cnt <= '0;
      primed    <= '0;
      for (int i = 0; i < NUM_SENSORS; i++) begin
        angle[i]  <= '0;
        valid[i]  <= 1'b0;
        error[i]  <= 1'b0;
        errcnt[i] <= '0;
      end
    end else begin
      if (state == S_UPDATE) begin
        frame_cnt <= frame_cnt + 16'd1;
        for (int i = 0; i < NUM_SENSORS; i++) begin
          if (idx == IDX_W'(i)) begin
            primed[i] <= 1'b1;
            // The first response after enable belongs to a stale command: drop it.
            if (primed[i]) begin
              if (rx_err) begin
                error[i] <= 1'b1;
                if (errcnt[i] != 16'hFFFF) errcnt[i] <= errcnt[i] + 16'd1;
              end else begin
                angle[i] <= rx_sr[ANGLE_BITS-1:0];
                valid[i] <= 1'b1;
                error[i] <= 1'b0;
              end
            end
          end
        end
      end

      // Bus writes come last so a counter clear beats a same-cycle increment.
      if (write) begin
        if (address == 8'h00) begin
          ctrl_en <= writedata[0];
          if (writedata[0] && !ctrl_en) primed <= '0;
        end
        if (address == 8'h01) mask <= writedata[NUM_SENSORS-1:0];
        for (int i = 0; i < NUM_SENSORS; i++) begin
          if (int'(address) == 'h30 + i) errcnt[i] <= '0;
        end
      end
    end
  end

  always_comb begin
    rd_val = '0;
    if (address == 8'h00) begin
      rd_val[0] = ctrl_en;
    end else if (address == 8'h01) begin
      rd_val[NUM_SENSORS-1:0] = mask;
    end else if (address == 8'h02) begin
      rd_val = {frame_cnt, 8'(idx), 7'd0, busy};
    end else begin
      for (int i = 0; i < NUM_SENSORS; i++) begin
        if (int'(address) == 'h10 + i) begin
          rd_val[ANGLE_BITS-1:0] = angle[i];
          rd_val[30]             = error[i];
          rd_val[31]             = valid[i];
        end
        if (int'(address) == 'h30 + i) rd_val[15:0] = errcnt[i];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset)     readdata <= '0;
    else if (read) readdata <= rd_val;
  end

endmodule

// File: tb/tb_angle_sensor_poller.sv
// Directed bench for angle_sensor_poller: an SPI mode-1 sensor model plus register-level checks.
module tb_angle_sensor_poller;

  localparam int NS = 9;
  localparam int CD = 4;
  localparam int GC = 3;
  localparam int AB = 14;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [7:0]    address = '0;
  logic          read = 1'b0;
  logic [31:0]   readdata;
  logic          write = 1'b0;
  logic [31:0]   writedata = '0;
  logic          waitrequest;
  logic          angle_miso = 1'b0;
  logic          angle_mosi;
  logic          angle_sck;
  logic [NS-1:0] angle_ss_n_o;

  int total = 0;
  int bad   = 0;

  logic [15:0] resp [NS];
  int  sel_q[$];
  int  rises = 0;
  int  last_rises = 0;
  int  cur_sel = 0;
  int  cyc = 0;
  int  last_rise_c = 0;
  bit  period_bad = 0;
  bit  mosi_bad = 0;
  logic any_sel;
  logic any_sel_p = 1'b0;
  logic sck_p = 1'b0;

  angle_sensor_poller #(
    .NUM_SENSORS(NS), .CLK_DIV(CD), .GAP_CYCLES(GC), .ANGLE_BITS(AB)
  ) dut (
    .clock(clock), .reset(reset), .address(address), .read(read), .readdata(readdata),
    .write(write), .writedata(writedata), .waitrequest(waitrequest),
    .angle_miso(angle_miso), .angle_mosi(angle_mosi), .angle_sck(angle_sck),
    .angle_ss_n_o(angle_ss_n_o)
  );

  always #5 clock = ~clock;

  assign any_sel = ~&angle_ss_n_o;

  // Sensor model and bus monitor, sampled on the falling clock edge.
  always @(negedge clock) begin
    logic [15:0] w;
    cyc++;
    if (any_sel && !any_sel_p) begin
      for (int i = 0; i < NS; i++) if (angle_ss_n_o[i] === 1'b0) cur_sel = i;
      sel_q.push_back(cur_sel);
      rises = 0;
    end
    if (!any_sel && any_sel_p) last_rises = rises;
    if (angle_sck && !sck_p) begin
      if (any_sel && rises < 16) begin
        w = resp[cur_sel];
        angle_miso = w[15 - rises];
      end
      if (rises > 0 && (cyc - last_rise_c) != 2 * CD) period_bad = 1;
      last_rise_c = cyc;
      rises++;
    end
    if (!angle_sck && sck_p && angle_mosi !== 1'b1) mosi_bad = 1;
    any_sel_p = any_sel;
    sck_p = angle_sck;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1; read = 1'b0; write = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic bus_write(input logic [7:0] a, input logic [31:0] d);
    @(negedge clock);
    address = a; writedata = d; write = 1'b1;
    @(negedge clock);
    write = 1'b0;
  endtask

  task automatic bus_read(input logic [7:0] a, output logic [31:0] d);
    @(negedge clock);
    address = a; read = 1'b1;
    @(negedge clock);
    read = 1'b0;
    d = readdata;
  endtask

  task automatic wait_frames(input int target);
    logic [31:0] d;
    bit ok = 0;
    for (int n = 0; n < 2000 && !ok; n++) begin
      bus_read(8'h02, d);
      if (int'(d[31:16]) >= target) ok = 1;
    end
    if (!ok) begin
      total++; bad++;
      $display("FAIL wait_frames: frame counter %0d, needed %0d", d[31:16], target);
    end
  endtask

  task automatic wait_idle();
    logic [31:0] d;
    bit ok = 0;
    for (int n = 0; n < 2000 && !ok; n++) begin
      bus_read(8'h02, d);
      if (d[0] == 1'b0) ok = 1;
    end
    if (!ok) begin
      total++; bad++;
      $display("FAIL wait_idle: STAT=%h, busy never dropped", d);
    end
  endtask

  task automatic test_reset();
    logic [31:0] d;
    do_reset();
    total++; if (angle_ss_n_o !== '1) begin bad++; $display("FAIL reset_ss_n: got %b want all ones", angle_ss_n_o); end
    total++; if (angle_sck !== 1'b0) begin bad++; $display("FAIL reset_sck: got %b want 0", angle_sck); end
    total++; if (angle_mosi !== 1'b0) begin bad++; $display("FAIL reset_mosi: got %b want 0", angle_mosi); end
    total++; if (waitrequest !== 1'b0) begin bad++; $display("FAIL waitrequest: got %b want 0", waitrequest); end
    bus_read(8'h01, d);
    total++; if (d !== 32'h0000_01FF) begin bad++; $display("FAIL reset_mask: got %h want 000001ff", d); end
    bus_read(8'h10, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL reset_angle0: got %h want 0", d); end
    bus_read(8'h02, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL reset_stat: got %h want 0", d); end
    bus_read(8'h05, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL unmapped_05: got %h want 0", d); end
    bus_read(8'h19, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL unmapped_19: got %h want 0", d); end
  endtask

  task automatic test_single_sensor();
    logic [31:0] d;
    bus_write(8'h01, 32'h001);
    bus_write(8'h00, 32'h1);
    wait_frames(1);
    bus_read(8'h10, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL first_frame_discard: got %h want 0", d); end
    wait_frames(2);
    bus_read(8'h10, d);
    total++; if (d !== 32'h8000_1234) begin bad++; $display("FAIL single_angle0: got %h want 80001234", d); end
    total++; if (last_rises !== 16) begin bad++; $display("FAIL sck_pulses: got %0d want 16", last_rises); end
    total++; if (period_bad !== 1'b0) begin bad++; $display("FAIL sck_period: got irregular want %0d clocks", 2 * CD); end
    total++; if (mosi_bad !== 1'b0) begin bad++; $display("FAIL mosi_cmd: got a 0 bit want all ones"); end
  endtask

  task automatic test_round_robin();
    int exp_order[6] = '{0, 2, 8, 0, 2, 8};
    int base;
    do_reset();
    base = sel_q.size();
    bus_write(8'h01, 32'h105);
    bus_write(8'h00, 32'h1);
    for (int n = 0; n < 3000 && sel_q.size() < base + 7; n++) @(negedge clock);
    if (sel_q.size() < base + 7) begin
      total++; bad++;
      $display("FAIL rr_timeout: got %0d selections want 7", sel_q.size() - base);
    end else begin
      for (int k = 0; k < 6; k++) begin
        total++;
        if (sel_q[base + k] != exp_order[k]) begin
          bad++;
          $display("FAIL rr_order[%0d]: got %0d want %0d", k, sel_q[base + k], exp_order[k]);
        end
      end
    end
  endtask

  task automatic test_parity_error();
    logic [31:0] d;
    int f;
    for (int n = 0; n < 3000 && angle_ss_n_o[0] !== 1'b0; n++) @(negedge clock);
    if (angle_ss_n_o[0] !== 1'b0) begin
      total++; bad++;
      $display("FAIL perr_wait_sel0: got ss_n %b want bit0 low", angle_ss_n_o);
    end
    resp[2] = 16'h9235;
    bus_read(8'h02, d);
    f = int'(d[31:16]);
    wait_frames(f + 2);
    bus_write(8'h00, 32'h0);
    wait_idle();
    resp[2] = 16'h9234;
    bus_read(8'h12, d);
    total++; if (d !== 32'hC000_1234) begin bad++; $display("FAIL perr_angle2: got %h want c0001234", d); end
    bus_read(8'h32, d);
    total++; if (d !== 32'h1) begin bad++; $display("FAIL perr_errcnt2: got %h want 1", d); end
    bus_read(8'h10, d);
    total++; if (d !== 32'h8000_1234) begin bad++; $display("FAIL perr_angle0: got %h want 80001234", d); end
    bus_write(8'h32, 32'h0);
    bus_read(8'h32, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL errcnt_clear: got %h want 0", d); end
  endtask

  task automatic test_disable_mid_shift();
    logic [31:0] d;
    do_reset();
    resp[0] = 16'h8ABC;
    bus_write(8'h01, 32'h001);
    bus_write(8'h00, 32'h1);
    wait_frames(1);
    for (int n = 0; n < 3000 && !(angle_ss_n_o[0] === 1'b0 && rises == 5); n++) @(negedge clock);
    if (!(angle_ss_n_o[0] === 1'b0 && rises == 5)) begin
      total++; bad++;
      $display("FAIL dis_wait_bit5: got rises %0d want 5", rises);
    end
    bus_write(8'h00, 32'h0);
    total++; if (angle_ss_n_o[0] !== 1'b0) begin bad++; $display("FAIL dis_frame_continues: got ss_n %b want bit0 low", angle_ss_n_o); end
    wait_idle();
    bus_read(8'h10, d);
    total++; if (d !== 32'h8000_0ABC) begin bad++; $display("FAIL dis_commit: got %h want 80000abc", d); end
    bus_read(8'h02, d);
    total++; if (d !== 32'h0002_0000) begin bad++; $display("FAIL dis_stat: got %h want 00020000", d); end
    total++; if (angle_ss_n_o !== '1) begin bad++; $display("FAIL dis_ss_n_idle: got %b want all ones", angle_ss_n_o); end
    resp[0] = 16'h9234;
  endtask

  task automatic test_saturation_and_reset();
    logic [31:0] d;
    do_reset();
    dut.errcnt[1] = 16'hFFFE;
    resp[1] = 16'h9235;
    bus_write(8'h01, 32'h002);
    bus_write(8'h00, 32'h1);
    wait_frames(3);
    bus_read(8'h31, d);
    total++; if (d !== 32'h0000_FFFF) begin bad++; $display("FAIL sat_errcnt1: got %h want 0000ffff", d); end
    bus_read(8'h11, d);
    total++; if (d !== 32'h4000_0000) begin bad++; $display("FAIL sat_angle1: got %h want 40000000", d); end
    for (int n = 0; n < 3000 && !(angle_ss_n_o[1] === 1'b0 && rises >= 3); n++) @(negedge clock);
    if (!(angle_ss_n_o[1] === 1'b0 && rises >= 3)) begin
      total++; bad++;
      $display("FAIL rst_wait_frame: got rises %0d want >=3", rises);
    end
    reset = 1'b1;
    @(negedge clock);
    total++; if (angle_ss_n_o !== '1) begin bad++; $display("FAIL midreset_ss_n: got %b want all ones", angle_ss_n_o); end
    total++; if (angle_sck !== 1'b0) begin bad++; $display("FAIL midreset_sck: got %b want 0", angle_sck); end
    repeat (2) @(negedge clock);
    reset = 1'b0;
    bus_read(8'h31, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL midreset_errcnt1: got %h want 0", d); end
    bus_read(8'h02, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL midreset_stat: got %h want 0", d); end
    bus_read(8'h00, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL midreset_ctrl: got %h want 0", d); end
    resp[1] = 16'h9234;
  endtask

  initial begin
    for (int i = 0; i < NS; i++) resp[i] = 16'h9234;
    test_reset();
    test_single_sensor();
    test_round_robin();
    test_parity_error();
    test_disable_mid_shift();
    test_saturation_and_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
